// File: rtl/decoder_stream.sv
// decoder_stream: registered, streaming binary-to-line decoder.
//   A WIDTH-bit code is accepted over a valid/ready handshake. It is decoded
//   according to mode (0=one-hot, 1=thermometer, 2=sticky OR accumulate,
//   3=toggle) into a 2**WIDTH-bit line vector, which is held in a
//   single-stage output register.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake carrying code and mode
//   code, mode           binary code and decode mode, sampled on accept
//   clr                  clears the accumulator (applied before any update)
//   out_valid/out_ready  output handshake for line
//   line                 decoded result
//   acc                  accumulator register used by ACCUM/TOGGLE
//   count                accepted transfers, saturating at 2**CNT_W-1
module decoder_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      code,
  input  logic [1:0]            mode,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**WIDTH-1:0]   line,
  output logic [2**WIDTH-1:0]   acc,
  output logic [CNT_W-1:0]      count
);
  localparam int LINES = 2**WIDTH;

  localparam logic [1:0] M_ONEHOT = 2'd0;
  localparam logic [1:0] M_THERMO = 2'd1;
  localparam logic [1:0] M_ACCUM  = 2'd2;
  localparam logic [1:0] M_TOGGLE = 2'd3;

  logic             accept;
  logic             xfer;
  logic [LINES-1:0] oh;
  logic [LINES-1:0] thermo;
  logic [LINES-1:0] acc_base;
  logic [LINES-1:0] acc_n;
  logic [LINES-1:0] line_n;

  // A single register stage: a new code can enter whenever the held one is
  // empty or is leaving this cycle, so an always-ready consumer sees no bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    oh       = '0;
    oh[code] = 1'b1;
  end

  // Thermometer: bit i is set for every i <= code.
  for (genvar i = 0; i < LINES; i++) begin : g_thermo
    localparam logic [WIDTH:0] IDX = (WIDTH+1)'(i);
    assign thermo[i] = (IDX <= {1'b0, code});
  end

  // Clear takes effect before this cycle's accumulate/toggle update.
  assign acc_base = clr ? '0 : acc;

  always_comb begin
    acc_n  = acc_base;
    line_n = oh;
    case (mode)
      M_ONEHOT: line_n = oh;
      M_THERMO: line_n = thermo;
      M_ACCUM: begin
        acc_n  = acc_base | oh;
        line_n = acc_n;
      end
      M_TOGGLE: begin
        acc_n  = acc_base ^ oh;
        line_n = acc_n;
      end
      default: line_n = oh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      line      <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      if (accept) begin
        line      <= line_n;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      // acc_n is acc_base for ONEHOT/THERMO, so clr is honoured on any cycle.
      if (accept) acc <= acc_n;
      else if (clr) acc <= '0;
      if (accept && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_stream.sv
module tb_decoder_stream;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [W-1:0] code = '0;
  logic [1:0]  mode = 2'd0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [15:0] line, acc;
  logic [7:0]  count;
  logic        in_ready_s, out_valid_s;
  logic [15:0] line_s, acc_s;
  logic [1:0]  count_s;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  logic [15:0] m_line, m_acc;
  logic        m_valid;
  int          m_cnt;

  always #5 clk = ~clk;

  decoder_stream #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .mode(mode), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .line(line), .acc(acc), .count(count));

  decoder_stream #(.WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .code(code), .mode(mode), .clr(clr), .out_valid(out_valid_s),
    .out_ready(out_ready), .line(line_s), .acc(acc_s), .count(count_s));

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Advance one clock: derive the model's next state from the spec rules,
  // take the edge, then settle 1 time unit past it.
  task automatic step();
    logic [15:0] nl, na, base;
    logic        nv, rdy;
    int          nc;
    bit [31:0]   ohv;
    nl = m_line; na = m_acc; nv = m_valid; nc = m_cnt;
    rdy = !m_valid || out_ready;
    base = clr ? 16'h0 : m_acc;
    ohv = 32'd1 << code;
    if (rst) begin
      nl = '0; na = '0; nv = 1'b0; nc = 0;
    end else if (in_valid && rdy) begin
      na = base;
      case (mode)
        2'd0: nl = ohv[15:0];
        2'd1: nl = 16'((ohv << 1) - 1);
        2'd2: begin na = base | ohv[15:0]; nl = na; end
        default: begin na = base ^ ohv[15:0]; nl = na; end
      endcase
      nv = 1'b1;
      nc = m_cnt + 1;
    end else begin
      na = base;
      if (m_valid && out_ready) nv = 1'b0;
    end
    @(posedge clk);
    m_line = nl; m_acc = na; m_valid = nv; m_cnt = nc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; code = 4'd5; out_ready = 1'b1;
    step(); step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (line !== 16'h0) $display("FAIL reset_line got=%h exp=0000", line); else n_pass++;
    n_chk++; if (acc !== 16'h0) $display("FAIL reset_acc got=%h exp=0000", acc); else n_pass++;
    n_chk++; if (count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    rst = 1'b0; in_valid = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_onehot();
    logic [15:0] exp_l [3] = '{16'h0001, 16'h0008, 16'h8000};
    logic [3:0]  codes [3] = '{4'd0, 4'd3, 4'd15};
    out_ready = 1'b1; mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code = codes[i]; #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL onehot_in_ready[%0d] got=%b exp=1", i, in_ready); else n_pass++;
      step();
      n_chk++; if (line !== exp_l[i] || out_valid !== 1'b1)
        $display("FAIL onehot_line[%0d] got=%h/%b exp=%h/1", i, line, out_valid, exp_l[i]); else n_pass++;
    end
    in_valid = 1'b0;
    n_chk++; if (count !== 8'd3) $display("FAIL onehot_count got=%0d exp=3", count); else n_pass++;
  endtask

  task automatic test_thermo();
    logic [15:0] exp_l [3] = '{16'h0001, 16'h00FF, 16'hFFFF};
    logic [3:0]  codes [3] = '{4'd0, 4'd7, 4'd15};
    out_ready = 1'b1; mode = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code = codes[i];
      step();
      n_chk++; if (line !== exp_l[i]) $display("FAIL thermo_line[%0d] got=%h exp=%h", i, line, exp_l[i]); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_accum_toggle();
    logic [1:0]  modes [4] = '{2'd2, 2'd2, 2'd3, 2'd2};
    logic [3:0]  codes [4] = '{4'd1, 4'd4, 4'd1, 4'd2};
    logic        clrs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_l [4] = '{16'h0002, 16'h0012, 16'h0010, 16'h0004};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode = modes[i]; code = codes[i]; clr = clrs[i];
      step();
      n_chk++; if (line !== exp_l[i] || acc !== exp_l[i])
        $display("FAIL accum_line[%0d] got=%h acc=%h exp=%h", i, line, acc, exp_l[i]); else n_pass++;
    end
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    n_chk++; if (acc !== 16'h0) $display("FAIL clr_acc got=%h exp=0000", acc); else n_pass++;
    n_chk++; if (line !== 16'h0004) $display("FAIL clr_line_hold got=%h exp=0004", line); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; mode = 2'd0; code = 4'd2; in_valid = 1'b1;
    step();
    n_chk++; if (out_valid !== 1'b1 || line !== 16'h0004)
      $display("FAIL bp_first got=%b/%h exp=1/0004", out_valid, line); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
    code = 4'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (line !== 16'h0004 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_stall[%0d] got=%h/%b/%b exp=0004/1/0", i, line, out_valid, in_ready); else n_pass++;
    end
    out_ready = 1'b1; code = 4'd9; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    n_chk++; if (line !== 16'h0200 || out_valid !== 1'b1)
      $display("FAIL bp_release got=%h/%b exp=0200/1", line, out_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin code = 4'(i); step(); end
    n_chk++; if (count_s !== 2'd3) $display("FAIL sat_count got=%0d exp=3", count_s); else n_pass++;
    n_chk++; if (count !== 8'(sat(m_cnt, 255))) $display("FAIL wide_count got=%0d exp=%0d", count, sat(m_cnt, 255)); else n_pass++;
    out_ready = 1'b0; code = 4'd6;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (out_valid_s !== 1'b0 || line_s !== 16'h0 || acc_s !== 16'h0 || count_s !== 2'd0)
      $display("FAIL midstall_reset got=%b/%h/%h/%0d exp=0/0000/0000/0", out_valid_s, line_s, acc_s, count_s); else n_pass++;
    n_chk++; if (out_valid !== 1'b0 || line !== 16'h0 || count !== 8'd0)
      $display("FAIL midstall_reset_wide got=%b/%h/%0d exp=0/0000/0", out_valid, line, count); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      code = 4'($urandom_range(0, 15));
      mode = 2'($urandom_range(0, 3));
      clr = 1'($urandom_range(0, 9) == 0);
      #1;
      n_chk++; if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, !m_valid || out_ready); else n_pass++;
      step();
      n_chk++; if (line !== m_line || out_valid !== m_valid || acc !== m_acc)
        $display("FAIL rnd_state[%0d] got=%h/%b/%h exp=%h/%b/%h", i, line, out_valid, acc, m_line, m_valid, m_acc); else n_pass++;
      n_chk++; if (count !== 8'(sat(m_cnt, 255)) || count_s !== 2'(sat(m_cnt, 3)))
        $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d/%0d", i, count, count_s, sat(m_cnt, 255), sat(m_cnt, 3)); else n_pass++;
    end
    in_valid = 1'b0; clr = 1'b0;
  endtask

  initial begin
    m_line = '0; m_acc = '0; m_valid = 1'b0; m_cnt = 0;
    test_reset();
    test_onehot();
    test_thermo();
    test_accum_toggle();
    test_backpressure();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
